data_mem_responder: RTL and testbench

Memory-side responder for the CPU data bus. It accepts one load/store request at a time over a valid/ready handshake and applies a configurable number of wait states. It performs the word access with byte-lane enables and returns read data or a completion through a response handshake. It sits opposite the datapath's address/write-data/read-data port and models slow data RAM for multi-cycle and stall testing.

---
 rtl/data_mem_responder.sv | 130 +++++++++++++
 tb/tb_data_mem_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Slow data-RAM responder for the CPU data bus: one request at a time,
// WAIT_STATES extra cycles, then a held response carrying load data or an error.
module data_mem_responder #(
  parameter int  DEPTH       = 64,
  parameter int  WAIT_STATES = 2,
  localparam int ADDR_W      = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_byte_en,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [1:0]  state_dbg
);

  // Handshakes: a request transfers on the rising edge where req_valid && req_ready;
  // a response transfers on the edge where resp_valid && resp_ready. The side
  // holding valid keeps its payload stable until that edge.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept, commit;

  logic        lat_write;
  logic [31:0] lat_addr, lat_wdata;
  logic [3:0]  lat_be;

  logic        c_write, c_err;
  logic [31:0] c_addr, c_wdata;
  logic [3:0]  c_be;
  logic [ADDR_W-1:0] c_idx;

  logic [31:0] mem [DEPTH];

  assign req_ready  = (state == S_IDLE) && reset;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == S_RESP);
  assign state_dbg  = state;

  // With zero wait states the commit happens on the accept edge itself,
  // so the live request is used instead of the latched copy.
  assign c_write = (state == S_IDLE) ? req_write   : lat_write;
  assign c_addr  = (state == S_IDLE) ? req_addr    : lat_addr;
  assign c_wdata = (state == S_IDLE) ? req_wdata   : lat_wdata;
  assign c_be    = (state == S_IDLE) ? req_byte_en : lat_be;
  assign c_idx   = c_addr[ADDR_W+1:2];
  assign c_err   = (c_addr[1:0] != 2'b00) || (c_addr[31:ADDR_W+2] != '0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_nxt = S_RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = S_RESP;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      resp_rdata <= 32'd0;
      resp_error <= 1'b0;
      lat_write  <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      lat_be     <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_byte_en;
      end
      if (commit) begin
        resp_error <= c_err;
        resp_rdata <= (!c_write && !c_err) ? mem[c_idx] : 32'd0;
      end
    end
  end

  // Storage is deliberately not reset; commit is impossible while reset is low.
  always_ff @(posedge clk) begin
    if (commit && c_write && !c_err) begin
      for (int i = 0; i < 4; i++) begin
        if (c_be[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed and random loads/stores against an
// array model of the RAM, plus a zero-wait-state instance for back-to-back traffic.
module tb_data_mem_responder;

  localparam int WS    = 2;
  localparam int DEPTH = 64;

  logic        clk;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_byte_en;
  logic        resp_valid, resp_ready, resp_error;
  logic [31:0] resp_rdata;
  logic [1:0]  state_dbg;

  logic        req_valid0, req_ready0, req_write0;
  logic [31:0] req_addr0, req_wdata0;
  logic [3:0]  req_byte_en0;
  logic        resp_valid0, resp_ready0, resp_error0;
  logic [31:0] resp_rdata0;
  logic [1:0]  state_dbg0;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [32:0] exp_q [$];

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_byte_en(req_byte_en),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error), .state_dbg(state_dbg)
  );

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_byte_en(req_byte_en0),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0),
    .resp_rdata(resp_rdata0), .resp_error(resp_error0), .state_dbg(state_dbg0)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: computes the response purely from the address rules.
  function automatic logic [32:0] model(input logic wr, input logic [31:0] addr,
                                        input logic [31:0] wd, input logic [3:0] be);
    logic        err;
    logic [31:0] rd;
    int          idx;
    err = (addr % 4 != 0) || (addr >= 4 * DEPTH);
    idx = int'(addr / 4) % DEPTH;
    rd  = 32'd0;
    if (!err) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        rd = ref_mem[idx];
      end
    end
    return {err, rd};
  endfunction

  // Driver: one full transaction, holding resp_ready low for 'hold' cycles.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int hold);
    logic [32:0] exp;
    int          n;
    exp_q.push_back(model(wr, addr, wd, be));
    @(negedge clk);
    req_valid   = 1'b1;
    req_write   = wr;
    req_addr    = addr;
    req_wdata   = wd;
    req_byte_en = be;
    resp_ready  = (hold == 0);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid   = 1'b0;
    req_write   = 1'($urandom_range(0, 1));
    req_addr    = $urandom;
    req_wdata   = $urandom;
    req_byte_en = 4'($urandom_range(0, 15));
    n = 1;
    while (!resp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("resp_latency", 32'(n), 32'(WS + 1));
    exp = exp_q.pop_front();
    check("resp_error", 32'(resp_error), 32'(exp[32]));
    check("resp_rdata", resp_rdata, exp[31:0]);
    for (int i = 0; i < hold; i++) begin
      req_valid = (i == 0);
      @(negedge clk);
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, exp[31:0]);
      check("hold_error", 32'(resp_error), 32'(exp[32]));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    check("post_resp_valid", 32'(resp_valid), 32'd0);
    check("post_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] a, last0;
    logic        wr;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_byte_en = 0; resp_ready = 1;
    req_valid0 = 0; req_write0 = 0; req_addr0 = 0; req_wdata0 = 0; req_byte_en0 = 0; resp_ready0 = 1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_error", 32'(resp_error), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rel_req_ready", 32'(req_ready), 32'd1);

    // Give every word a known value so later loads never see X.
    for (int i = 0; i < DEPTH; i++) do_txn(1'b1, 32'(i * 4), $urandom, 4'hF, 0);

    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
    check("load_deadbeef", ref_mem[4], 32'hDEADBEEF);
    do_txn(1'b1, 32'h20, 32'h11223344, 4'hF, 0);
    do_txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0);
    do_txn(1'b0, 32'h20, 32'h0, 4'h0, 1);
    check("merge_model", ref_mem[8], 32'h11BB33DD);
    do_txn(1'b1, 32'h20, 32'h55555555, 4'b0000, 0);
    do_txn(1'b0, 32'h20, 32'h0, 4'h0, 0);
    do_txn(1'b0, 32'h22, 32'h0, 4'h0, 0);
    do_txn(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 0);
    do_txn(1'b0, 32'h0, 32'h0, 4'h0, 0);
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 5);

    // Reset during WAIT of a store: memory must stay at its prior value.
    do_txn(1'b1, 32'h30, 32'h0, 4'hF, 0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30;
    req_wdata = 32'h12345678; req_byte_en = 4'hF; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("pre_rst_state_wait", 32'(state_dbg), 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("midrst_resp_valid", 32'(resp_valid), 32'd0);
      check("midrst_resp_rdata", resp_rdata, 32'd0);
      check("midrst_req_ready", 32'(req_ready), 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    check("midrst_release_ready", 32'(req_ready), 32'd1);
    check("midrst_release_valid", 32'(resp_valid), 32'd0);
    do_txn(1'b0, 32'h30, 32'h0, 4'h0, 0);

    // Randomised traffic with occasional bad addresses and back-pressure.
    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 9))
        0: a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
        1: begin
          a = $urandom;
          if (a[31:8] == 24'd0) a[8] = 1'b1;
        end
        default: a = 32'($urandom_range(0, DEPTH - 1) * 4);
      endcase
      wr = 1'($urandom_range(0, 1));
      do_txn(wr, a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
    end

    // Zero wait states, req_valid and resp_ready held high, store/load alternating.
    last0 = 32'd0;
    @(negedge clk);
    req_valid0 = 1'b1;
    resp_ready0 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("ws0_req_ready", 32'(req_ready0), 32'd1);
      req_write0   = (k % 2 == 0);
      req_addr0    = 32'h4;
      req_wdata0   = $urandom;
      req_byte_en0 = 4'hF;
      if (req_write0) last0 = req_wdata0;
      @(negedge clk);
      check("ws0_resp_valid", 32'(resp_valid0), 32'd1);
      check("ws0_busy", 32'(req_ready0), 32'd0);
      check("ws0_resp_error", 32'(resp_error0), 32'd0);
      check("ws0_resp_rdata", resp_rdata0, (k % 2 == 0) ? 32'd0 : last0);
      @(negedge clk);
    end
    req_valid0 = 1'b0;
    check("ws0_idle", 32'(resp_valid0), 32'd0);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
